// File: rtl/fp_half_to_int.sv
// fp_half_to_int: multi-cycle binary16 to signed integer converter, round-to-nearest-even with saturation.
module fp_half_to_int #(
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_half,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_int,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  localparam logic [40:0] MAX_POS = (41'd1 << (OUT_W - 1)) - 41'd1;
  localparam logic [40:0] MAX_NEG = 41'd1 << (OUT_W - 1);
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  state_t state, state_n;
  logic sign, guard, sticky, lft, left, is_nan, is_inf, is_tiny, inc, sat;
  logic [4:0] count, e, e_eff, diff;
  logic [9:0] frac;
  logic [39:0] mag;
  logic [40:0] r;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    e = in_half[14:10];
    frac = in_half[9:0];
    e_eff = (e == 5'd0) ? 5'd1 : e;
    is_nan = (&e) && (|frac);
    is_inf = (&e) && !(|frac);
    // below 0.5 in magnitude always rounds to zero
    is_tiny = !(|in_half[14:0]) || e_eff <= 5'd13;
    left = e_eff >= 5'd25;
    diff = left ? e_eff - 5'd25 : 5'd25 - e_eff;
    inc = guard & (sticky | mag[0]);
    r = {1'b0, mag} + {40'd0, inc};
    sat = sign ? r > MAX_NEG : r > MAX_POS;
    state_n = state;
    case (state)
      IDLE:  if (in_valid) state_n = (is_nan || is_inf || is_tiny) ? DONE : (diff == 5'd0) ? ROUND : SHIFT;
      SHIFT: if (count == 5'd1) state_n = ROUND;
      ROUND: state_n = DONE;
      DONE:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sign <= 1'b0;
      guard <= 1'b0;
      sticky <= 1'b0;
      lft <= 1'b0;
      count <= 5'd0;
      mag <= 40'd0;
      out_int <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          sign <= in_half[15];
          mag <= {29'd0, e != 5'd0, frac};
          guard <= 1'b0;
          sticky <= 1'b0;
          count <= diff;
          lft <= left;
          if (is_nan || is_inf || is_tiny) begin
            out_int <= is_inf ? (in_half[15] ? SAT_NEG : SAT_POS) : '0;
            ovf <= is_nan || is_inf;
          end
        end
        SHIFT: begin
          mag <= lft ? mag << 1 : mag >> 1;
          if (!lft) begin
            guard <= mag[0];
            sticky <= sticky | guard;
          end
          count <= count - 5'd1;
        end
        ROUND: begin
          out_int <= sat ? (sign ? SAT_NEG : SAT_POS) : sign ? -r[OUT_W-1:0] : r[OUT_W-1:0];
          ovf <= sat;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_half_to_int.sv
// tb_fp_half_to_int: directed vector table plus handshake and reset sequences for fp_half_to_int.
module tb_fp_half_to_int;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, ovf;
  logic [15:0] in_half = 16'd0;
  logic [15:0] out_int;
  int checks = 0, failures = 0;
  typedef struct {
    logic [15:0] half;
    logic [15:0] res;
    logic        ov;
    int          lat;
    string       name;
  } vec_t;
  vec_t vecs[$];
  fp_half_to_int #(.OUT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_half(in_half),
    .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic accept(input logic [15:0] h);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_half = h;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic collect(input string name, input logic [15:0] res, input logic ov, input int lat, input bit release_out);
    int n = 1;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_lat"}, n, lat);
    chk({name, "_int"}, {16'd0, out_int}, {16'd0, res});
    chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, ov});
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask
  initial begin
    vecs = '{
      '{16'h6400, 16'h0400, 1'b0, 2,  "v1024"},
      '{16'h3C00, 16'h0001, 1'b0, 12, "one"},
      '{16'hC500, 16'hFFFB, 1'b0, 10, "neg5"},
      '{16'h3E00, 16'h0002, 1'b0, 12, "tie1p5"},
      '{16'h4100, 16'h0002, 1'b0, 11, "tie2p5"},
      '{16'h3800, 16'h0000, 1'b0, 13, "half"},
      '{16'h3A00, 16'h0001, 1'b0, 13, "p075"},
      '{16'hBA00, 16'hFFFF, 1'b0, 13, "n075"},
      '{16'h7800, 16'h7FFF, 1'b1, 7,  "pos32768"},
      '{16'hF800, 16'h8000, 1'b0, 7,  "neg32768"},
      '{16'h7BFF, 16'h7FFF, 1'b1, 7,  "max_half"},
      '{16'h7C00, 16'h7FFF, 1'b1, 1,  "pinf"},
      '{16'hFC00, 16'h8000, 1'b1, 1,  "ninf"},
      '{16'h7E00, 16'h0000, 1'b1, 1,  "nan"},
      '{16'h0001, 16'h0000, 1'b0, 1,  "denorm"},
      '{16'h8000, 16'h0000, 1'b0, 1,  "negzero"},
      '{16'h1000, 16'h0000, 1'b0, 1,  "tiny"},
      '{16'h57FF, 16'h0080, 1'b0, 6,  "p127_94"},
      '{16'h4900, 16'h000A, 1'b0, 9,  "ten"},
      '{16'h3C01, 16'h0001, 1'b0, 12, "one_plus"}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_int", {16'd0, out_int}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      accept(vecs[i].half);
      collect(vecs[i].name, vecs[i].res, vecs[i].ov, vecs[i].lat, 1'b1);
      chk({vecs[i].name, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    end
    // stall in DONE with a pending operand, then let it through after the handshake
    accept(16'hC500);
    collect("stall", 16'hFFFB, 1'b0, 10, 1'b0);
    in_half = 16'h4900;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_int", {16'd0, out_int}, 32'h0000FFFB);
      chk("stall_ovf", {31'd0, ovf}, 32'd0);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accepted", {31'd0, in_ready}, 32'd0);
    collect("b2b", 16'h000A, 1'b0, 9, 1'b1);
    // reset while shifting abandons the operand
    accept(16'h3C00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_int", {16'd0, out_int}, 32'd0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 16; k++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      chk("mid_rst_no_output", {31'd0, seen}, 32'd0);
    end
    accept(16'h3E00);
    collect("post_rst", 16'h0002, 1'b0, 12, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
